// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: destination-select encodings, fixed register
// numbers and the stage-entry record carried by the destination pipeline.
package mips_pkg;

   typedef enum logic [1:0] {
      REG_DST_RT   = 2'b00,
      REG_DST_RD   = 2'b01,
      REG_DST_LINK = 2'b10,
      REG_DST_ILL  = 2'b11
   } reg_dst_e;

   localparam int REG_ZERO   = 0;
   localparam int REG_RA     = 31;

   // Widest register address a stage entry can hold; narrower addresses are zero-extended.
   localparam int MAX_ADDR_W = 8;

   typedef struct packed {
      logic                  valid;
      logic                  write;
      logic [MAX_ADDR_W-1:0] addr;
   } stage_t;

endpackage

// File: rtl/regdst_sel.sv
// Combinational destination-register select and effective write-enable for the
// instruction currently in decode.
module regdst_sel
   import mips_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int LINK_REG = REG_RA
) (
   input  logic [ADDR_W-1:0] inst_rt,
   input  logic [ADDR_W-1:0] inst_rd,
   input  logic [1:0]        reg_dst,
   input  logic              reg_write,
   input  logic              in_valid,
   output logic [ADDR_W-1:0] dest,
   output logic              eff_write,
   output logic              is_ill
);

   always_comb begin
      dest   = inst_rt;
      is_ill = 1'b0;
      case (reg_dst_e'(reg_dst))
         REG_DST_RT:   dest   = inst_rt;
         REG_DST_RD:   dest   = inst_rd;
         REG_DST_LINK: dest   = ADDR_W'(LINK_REG);
         REG_DST_ILL:  is_ill = 1'b1;
         default:      is_ill = 1'b1;
      endcase
      // $0 is hard-wired, so writes to it are dropped here rather than at write-back.
      eff_write = in_valid & reg_write & (dest != ADDR_W'(REG_ZERO)) & ~is_ill;
   end

endmodule

// File: rtl/regdst_pipe.sv
// Destination-register pipeline: carries {valid, write, addr} from decode to
// write-back through DEPTH stages and reports forwarding matches against decode sources.
module regdst_pipe
   import mips_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 3,
   parameter int LINK_REG = REG_RA,
   parameter int NUM_SRC  = 2,
   localparam int SW      = $clog2((DEPTH > 2) ? DEPTH : 2)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ADDR_W-1:0]         inst_rt,
   input  logic [ADDR_W-1:0]         inst_rd,
   input  logic [1:0]                reg_dst,
   input  logic                      reg_write,
   input  logic                      in_valid,
   input  logic                      stall,
   input  logic                      flush,
   input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
   output logic [ADDR_W-1:0]         wb_addr,
   output logic                      wb_en,
   output logic [NUM_SRC-1:0]        fwd_hit,
   output logic [NUM_SRC*SW-1:0]     fwd_stage,
   output logic                      illegal
);

   localparam stage_t BUBBLE = '0;

   logic [ADDR_W-1:0] dest;
   logic              eff_write;
   logic              is_ill;

   stage_t stage_d [DEPTH];
   stage_t stage_q [DEPTH];
   logic   illegal_d;
   logic   illegal_q;

   logic [NUM_SRC-1:0][DEPTH-1:0] hit;

   regdst_sel #(
      .ADDR_W   (ADDR_W),
      .LINK_REG (LINK_REG)
   ) u_sel (
      .inst_rt   (inst_rt),
      .inst_rd   (inst_rd),
      .reg_dst   (reg_dst),
      .reg_write (reg_write),
      .in_valid  (in_valid),
      .dest      (dest),
      .eff_write (eff_write),
      .is_ill    (is_ill)
   );

   // Only stage 0 honours stall; later stages always advance so in-flight results drain.
   always_comb begin
      stage_d[0] = stage_q[0];
      if (flush) begin
         stage_d[0] = BUBBLE;
      end else if (!stall) begin
         stage_d[0].valid = in_valid;
         stage_d[0].write = eff_write;
         stage_d[0].addr  = MAX_ADDR_W'(dest);
      end
      for (int k = 1; k < DEPTH; k++) begin
         stage_d[k] = (k == 1 && stall) ? BUBBLE : stage_q[k-1];
      end
      illegal_d = illegal_q | (in_valid & is_ill & ~flush & ~stall);
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) stage_q[k] <= BUBBLE;
         else        stage_q[k] <= stage_d[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) illegal_q <= 1'b0;
      else        illegal_q <= illegal_d;
   end

   assign illegal = illegal_q;
   assign wb_en   = stage_q[DEPTH-1].valid & stage_q[DEPTH-1].write;
   assign wb_addr = wb_en ? stage_q[DEPTH-1].addr[ADDR_W-1:0] : '0;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      for (genvar k = 0; k < DEPTH; k++) begin : g_k
         assign hit[s][k] = stage_q[k].valid & stage_q[k].write
                          & (stage_q[k].addr == MAX_ADDR_W'(src_addr[s*ADDR_W +: ADDR_W]))
                          & (src_addr[s*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO));
      end
   end

   // Scan oldest to youngest so the lowest matching stage index is the one left standing.
   always_comb begin
      fwd_hit   = '0;
      fwd_stage = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         fwd_hit[s] = |hit[s];
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit[s][k]) fwd_stage[s*SW +: SW] = SW'(k);
         end
      end
   end

endmodule

// File: tb/tb_regdst_pipe.sv
// Directed bench for regdst_pipe (DEPTH=3): table of per-cycle vectors plus
// hand-written reset and illegal-capture sequences.
module tb_regdst_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] inst_rt, inst_rd;
   logic [1:0] reg_dst;
   logic       reg_write, in_valid, stall, flush;
   logic [9:0] src_addr;
   logic [4:0] wb_addr;
   logic       wb_en;
   logic [1:0] fwd_hit;
   logic [3:0] fwd_stage;
   logic       illegal;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   regdst_pipe #(
      .ADDR_W   (5),
      .DEPTH    (3),
      .LINK_REG (31),
      .NUM_SRC  (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inst_rt   (inst_rt),
      .inst_rd   (inst_rd),
      .reg_dst   (reg_dst),
      .reg_write (reg_write),
      .in_valid  (in_valid),
      .stall     (stall),
      .flush     (flush),
      .src_addr  (src_addr),
      .wb_addr   (wb_addr),
      .wb_en     (wb_en),
      .fwd_hit   (fwd_hit),
      .fwd_stage (fwd_stage),
      .illegal   (illegal)
   );

   typedef struct {
      logic [4:0] rt, rd;
      logic [1:0] dst;
      logic       rw, v, st, fl;
      logic [4:0] s1, s0;
      logic       e_en;
      logic [4:0] e_addr;
      logic [1:0] e_hit;
      logic [3:0] e_stg;
      logic       e_ill;
   } vec_t;

   vec_t tbl [27];

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s [%0d]: got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] rt, input logic [4:0] rd, input logic [1:0] dst,
                        input logic rw, input logic v, input logic st, input logic fl,
                        input logic [4:0] s1, input logic [4:0] s0);
      inst_rt   = rt;
      inst_rd   = rd;
      reg_dst   = dst;
      reg_write = rw;
      in_valid  = v;
      stall     = st;
      flush     = fl;
      src_addr  = {s1, s0};
   endtask

   initial begin
      //         rt  rd dst rw v st fl s1  s0   en addr hit stg ill
      tbl[0]  = '{ 8,  9, 1, 1, 1, 0, 0, 0,  0,  0,  0, 0,  0, 0};
      tbl[1]  = '{ 0,  0, 0, 0, 0, 0, 0, 0,  9,  0,  0, 1,  1, 0};
      tbl[2]  = '{ 0,  0, 0, 0, 0, 0, 0, 9,  9,  1,  9, 3, 10, 0};
      tbl[3]  = '{ 0,  0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  0, 0};
      tbl[4]  = '{ 3,  4, 2, 1, 1, 0, 0, 0,  0,  0,  0, 0,  0, 0};
      tbl[5]  = '{ 0,  0, 0, 0, 0, 0, 0, 0, 31,  0,  0, 1,  1, 0};
      tbl[6]  = '{ 0,  0, 0, 0, 0, 0, 0, 0,  0,  1, 31, 0,  0, 0};
      tbl[7]  = '{ 0,  0, 1, 1, 1, 0, 0, 0,  0,  0,  0, 0,  0, 0};
      tbl[8]  = '{ 0,  0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  0, 0};
      tbl[9]  = '{ 0,  0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  0, 0};
      tbl[10] = '{ 0,  5, 1, 1, 1, 0, 0, 0,  0,  0,  0, 0,  0, 0};
      tbl[11] = '{ 0,  5, 1, 1, 1, 0, 0, 0,  5,  0,  0, 1,  0, 0};
      tbl[12] = '{ 0,  0, 0, 0, 0, 1, 0, 0,  5,  1,  5, 1,  0, 0};
      tbl[13] = '{ 0,  0, 0, 0, 0, 0, 0, 0,  5,  0,  0, 1,  1, 0};
      tbl[14] = '{ 0,  0, 0, 0, 0, 0, 0, 0,  5,  1,  5, 1,  2, 0};
      tbl[15] = '{ 0,  7, 1, 1, 1, 0, 0, 0,  0,  0,  0, 0,  0, 0};
      tbl[16] = '{ 0, 12, 1, 1, 1, 1, 0, 0,  7,  0,  0, 1,  0, 0};
      tbl[17] = '{ 0, 12, 1, 1, 1, 1, 0, 0,  7,  0,  0, 1,  0, 0};
      tbl[18] = '{ 0,  0, 0, 0, 0, 0, 0, 0,  7,  0,  0, 1,  1, 0};
      tbl[19] = '{ 0,  0, 0, 0, 0, 0, 0, 0,  7,  1,  7, 1,  2, 0};
      tbl[20] = '{ 0,  7, 1, 1, 1, 0, 0, 0,  0,  0,  0, 0,  0, 0};
      tbl[21] = '{ 0, 12, 1, 1, 1, 1, 1, 0,  7,  0,  0, 0,  0, 0};
      tbl[22] = '{ 0,  0, 0, 0, 0, 0, 0, 0,  7,  0,  0, 0,  0, 0};
      tbl[23] = '{ 0,  0, 0, 0, 0, 0, 0, 0,  7,  0,  0, 0,  0, 0};
      tbl[24] = '{ 6,  6, 3, 1, 1, 0, 0, 0,  6,  0,  0, 0,  0, 1};
      tbl[25] = '{ 0,  0, 0, 0, 0, 0, 0, 0,  6,  0,  0, 0,  0, 1};
      tbl[26] = '{ 0,  0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  0, 1};

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk("reset_wb_en",   -1, 32'(wb_en),     0);
      chk("reset_wb_addr", -1, 32'(wb_addr),   0);
      chk("reset_fwd_hit", -1, 32'(fwd_hit),   0);
      chk("reset_fwd_stg", -1, 32'(fwd_stage), 0);
      chk("reset_illegal", -1, 32'(illegal),   0);
      rst_n = 1'b1;

      for (int i = 0; i < 27; i++) begin
         @(negedge clk);
         drive(tbl[i].rt, tbl[i].rd, tbl[i].dst, tbl[i].rw, tbl[i].v,
               tbl[i].st, tbl[i].fl, tbl[i].s1, tbl[i].s0);
         @(posedge clk);
         #1;
         chk("wb_en",     i, 32'(wb_en),     32'(tbl[i].e_en));
         chk("wb_addr",   i, 32'(wb_addr),   32'(tbl[i].e_addr));
         chk("fwd_hit",   i, 32'(fwd_hit),   32'(tbl[i].e_hit));
         chk("fwd_stage", i, 32'(fwd_stage), 32'(tbl[i].e_stg));
         chk("illegal",   i, 32'(illegal),   32'(tbl[i].e_ill));
      end

      // Fill all three stages with dest 10, then pull reset in mid-cycle.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(0, 10, 1, 1, 1, 0, 0, 0, 0);
         @(posedge clk);
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 10);
      #1;
      chk("pre_rst_wb_en",   100, 32'(wb_en),     1);
      chk("pre_rst_wb_addr", 100, 32'(wb_addr),   10);
      chk("pre_rst_fwd_hit", 100, 32'(fwd_hit),   1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_wb_en",   101, 32'(wb_en),     0);
      chk("mid_rst_wb_addr", 101, 32'(wb_addr),   0);
      chk("mid_rst_fwd_hit", 101, 32'(fwd_hit),   0);
      chk("mid_rst_fwd_stg", 101, 32'(fwd_stage), 0);
      chk("mid_rst_illegal", 101, 32'(illegal),   0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("post_rst_wb_en", 102 + i, 32'(wb_en), 0);
      end

      // Illegal select is only captured when neither stalled nor flushed.
      @(negedge clk);
      drive(1, 2, 3, 1, 1, 1, 0, 0, 0);
      @(posedge clk); #1;
      chk("ill_stall", 110, 32'(illegal), 0);
      @(negedge clk);
      drive(1, 2, 3, 1, 1, 0, 1, 0, 0);
      @(posedge clk); #1;
      chk("ill_flush", 111, 32'(illegal), 0);
      @(negedge clk);
      drive(1, 2, 3, 1, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("ill_invalid", 112, 32'(illegal), 0);
      @(negedge clk);
      drive(1, 2, 3, 1, 1, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("ill_set", 113, 32'(illegal), 1);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("ill_sticky", 114, 32'(illegal), 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("ill_rst", 115, 32'(illegal), 0);
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
